// File: rtl/sorted_stream_merge.sv
// Two-way streaming merge of sorted frames A and B into one sorted frame.
// Registered output; the ready for each input is combinational from state and compare.

module ssm_order_chk #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             acc,
  input  logic [WIDTH-1:0] data,
  input  logic             last,
  output logic             err
);
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             has_q, has_d;

  always_comb begin
    prev_d = prev_q;
    has_d  = has_q;
    if (acc) begin
      prev_d = data;
      // The first element of the next frame must not be compared to this frame.
      has_d  = !last;
    end
  end

  assign err = acc && has_q && (data < prev_q);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      prev_q <= '0;
      has_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      has_q  <= has_d;
    end
  end
endmodule

module sorted_stream_merge #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  input  logic             a_last,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  input  logic             b_last,
  output logic             b_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             order_err,
  output logic [CNT_W-1:0] frame_count
);
  typedef enum logic [1:0] {MERGE, DRAIN_A, DRAIN_B} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             order_err_q, order_err_d;
  logic [CNT_W-1:0] frame_count_q, frame_count_d;
  logic             load_en, acc_a, acc_b, fc_inc;

  logic [1:0]            chk_acc, chk_last, chk_err;
  logic [1:0][WIDTH-1:0] chk_data;

  assign load_en = !out_valid_q || out_ready;
  assign acc_a   = a_valid && a_ready;
  assign acc_b   = b_valid && b_ready;
  assign fc_inc  = out_valid_q && out_ready && out_last_q;

  always_comb begin
    a_ready       = 1'b0;
    b_ready       = 1'b0;
    state_d       = state_q;
    out_data_d    = out_data_q;
    out_last_d    = out_last_q;
    out_valid_d   = out_valid_q && !out_ready;
    order_err_d   = order_err_q || (|chk_err);
    frame_count_d = frame_count_q + {{(CNT_W-1){1'b0}}, fc_inc};
    case (state_q)
      MERGE: begin
        // Both heads must be visible before either can be chosen; ties go to A.
        if (a_valid && b_valid && load_en) begin
          a_ready = (a_data <= b_data);
          b_ready = !(a_data <= b_data);
        end
      end
      DRAIN_B: b_ready = load_en;
      DRAIN_A: a_ready = load_en;
      default: ;
    endcase
    if (a_valid && a_ready) begin
      out_valid_d = 1'b1;
      out_data_d  = a_data;
      out_last_d  = (state_q == DRAIN_A) && a_last;
      if (a_last) state_d = (state_q == MERGE) ? DRAIN_B : MERGE;
    end else if (b_valid && b_ready) begin
      out_valid_d = 1'b1;
      out_data_d  = b_data;
      out_last_d  = (state_q == DRAIN_B) && b_last;
      if (b_last) state_d = (state_q == MERGE) ? DRAIN_A : MERGE;
    end
  end

  assign chk_acc  = {acc_b, acc_a};
  assign chk_last = {b_last, a_last};
  assign chk_data = {b_data, a_data};

  for (genvar s = 0; s < 2; s++) begin : g_chk
    ssm_order_chk #(.WIDTH(WIDTH)) u_chk (
      .clk  (clk),
      .rstN (rstN),
      .acc  (chk_acc[s]),
      .data (chk_data[s]),
      .last (chk_last[s]),
      .err  (chk_err[s])
    );
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q       <= MERGE;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      order_err_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      order_err_q   <= order_err_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign order_err   = order_err_q;
  assign frame_count = frame_count_q;
endmodule

// File: tb/tb_sorted_stream_merge.sv
// Scoreboard bench for sorted_stream_merge: drivers feed source queues, a monitor
// pops hand-computed expected {last,data} entries on each output handshake.

module tb_sorted_stream_merge;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk, rstN;
  logic [WIDTH-1:0] a_data, b_data, out_data;
  logic             a_valid, a_last, a_ready, b_valid, b_last, b_ready;
  logic             out_valid, out_last, out_ready, order_err;
  logic [CNT_W-1:0] frame_count;

  sorted_stream_merge #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstN(rstN),
    .a_data(a_data), .a_valid(a_valid), .a_last(a_last), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_last(b_last), .b_ready(b_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .order_err(order_err), .frame_count(frame_count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  logic [WIDTH:0] a_src[$], b_src[$], exp_q[$];
  int             pop_cyc[$];
  int             checks = 0, passed = 0;
  int             cyc = 0, a_cnt = 0, b_cnt = 0, ordy_mode = 0, exp_fc = 0;
  bit             tie_chk = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic pa(input int d, input bit l); a_src.push_back({l, 4'(d)}); endtask
  task automatic pb(input int d, input bit l); b_src.push_back({l, 4'(d)}); endtask
  task automatic pe(input int d, input bit l); exp_q.push_back({l, 4'(d)}); endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((a_src.size() != 0 || b_src.size() != 0 || exp_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk({name, "_timeout"}, 1, 0);
    @(negedge clk);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Source A driver
  initial begin
    logic acc;
    a_valid = 0; a_data = 0; a_last = 0;
    forever begin
      @(negedge clk);
      acc = a_valid && a_ready && rstN;
      @(posedge clk); #1;
      if (acc && a_src.size() > 0) begin void'(a_src.pop_front()); a_cnt++; end
      if (a_src.size() > 0) begin a_valid = 1; {a_last, a_data} = a_src[0]; end
      else begin a_valid = 0; a_last = 0; end
    end
  end

  // Source B driver
  initial begin
    logic acc;
    b_valid = 0; b_data = 0; b_last = 0;
    forever begin
      @(negedge clk);
      acc = b_valid && b_ready && rstN;
      @(posedge clk); #1;
      if (acc && b_src.size() > 0) begin void'(b_src.pop_front()); b_cnt++; end
      if (b_src.size() > 0) begin b_valid = 1; {b_last, b_data} = b_src[0]; end
      else begin b_valid = 0; b_last = 0; end
    end
  end

  // Downstream ready: 0 = always, 1 = pattern 1,0,0, 2 = stalled
  initial begin
    int ph;
    ph = 0;
    out_ready = 1;
    forever begin
      @(posedge clk); #1;
      case (ordy_mode)
        0: out_ready = 1;
        1: out_ready = (ph == 0);
        default: out_ready = 0;
      endcase
      ph = (ph == 2) ? 0 : ph + 1;
    end
  end

  // Monitor
  initial begin
    logic [WIDTH:0] e;
    forever begin
      @(negedge clk);
      if (rstN && out_valid) begin
        if (exp_q.size() == 0) chk("unexpected_out", int'({out_last, out_data}), -1);
        else if (out_ready) begin
          e = exp_q.pop_front();
          chk("out_elem", int'({out_last, out_data}), int'(e));
          pop_cyc.push_back(cyc);
          if (e[WIDTH]) exp_fc++;
        end else begin
          chk("stall_stable", int'({out_last, out_data}), int'(exp_q[0]));
        end
      end
      if (tie_chk && a_cnt == 2 && b_cnt < 3) chk("drain_a_ready", int'(a_ready), 0);
      if (a_ready && b_ready) chk("both_ready", 1, 0);
    end
  end

  initial begin
    int p0;
    rstN = 0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_order_err", int'(order_err), 0);
    chk("rst_frame_count", int'(frame_count), 0);
    #20 rstN = 1;
    @(negedge clk);

    // Basic merge with throughput check
    p0 = pop_cyc.size();
    pa(1,0); pa(4,0); pa(9,1);
    pb(2,0); pb(3,0); pb(15,1);
    pe(1,0); pe(2,0); pe(3,0); pe(4,0); pe(9,0); pe(15,1);
    wait_idle("basic");
    chk("basic_fc", int'(frame_count), 1);
    chk("basic_rate", pop_cyc[pop_cyc.size()-1] - pop_cyc[p0], 5);

    // Tie and drain; A's next frame waits with a smaller head during B's drain
    a_cnt = 0; b_cnt = 0; tie_chk = 1;
    pa(7,0); pa(7,1); pa(0,1);
    pb(7,0); pb(8,0); pb(12,1); pb(1,1);
    pe(7,0); pe(7,0); pe(7,0); pe(8,0); pe(12,1); pe(0,0); pe(1,1);
    wait_idle("tie");
    tie_chk = 0;
    chk("tie_fc", int'(frame_count), exp_fc % 256);
    chk("tie_fc_abs", int'(frame_count), 3);

    // Backpressure
    ordy_mode = 1;
    pa(1,0); pa(4,0); pa(9,1);
    pb(2,0); pb(3,0); pb(15,1);
    pe(1,0); pe(2,0); pe(3,0); pe(4,0); pe(9,0); pe(15,1);
    wait_idle("bp");
    ordy_mode = 0;
    chk("bp_fc", int'(frame_count), 4);
    chk("pre_order_err", int'(order_err), 0);

    // Order error
    pa(5,0); pa(3,1);
    pb(6,1);
    pe(5,0); pe(3,0); pe(6,1);
    wait_idle("order");
    chk("order_err_set", int'(order_err), 1);
    repeat (3) @(negedge clk);
    chk("order_err_sticky", int'(order_err), 1);
    chk("order_fc", int'(frame_count), 5);

    // Reset mid-frame with out_valid held
    ordy_mode = 2;
    pa(1,0); pa(4,0); pa(9,1);
    pb(2,0); pb(3,0); pb(15,1);
    pe(1,0); pe(2,0); pe(3,0); pe(4,0); pe(9,0); pe(15,1);
    repeat (5) @(posedge clk);
    #3;
    chk("pre_rst_valid", int'(out_valid), 1);
    rstN = 0;
    a_src.delete(); b_src.delete(); exp_q.delete();
    a_valid = 0; b_valid = 0; exp_fc = 0;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_fc", int'(frame_count), 0);
    chk("mid_rst_order_err", int'(order_err), 0);
    ordy_mode = 0;
    repeat (2) @(posedge clk);
    #3 rstN = 1;
    @(negedge clk);
    pa(2,1); pb(1,1);
    pe(1,0); pe(2,1);
    wait_idle("post_rst");
    chk("post_rst_fc", int'(frame_count), 1);

    // Counter wrap
    for (int i = 0; i < 255; i++) begin
      pa(0,1); pb(15,1); pe(0,0); pe(15,1);
    end
    wait_idle("wrap");
    chk("wrap_fc", int'(frame_count), 0);
    pa(0,1); pb(15,1); pe(0,0); pe(15,1);
    wait_idle("wrap2");
    chk("wrap2_fc", int'(frame_count), 1);
    chk("final_order_err", int'(order_err), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
